// File: rtl/fsk_demod_pkg.sv
// Shared types and helpers for the zero-crossing FSK demodulator.
package fsk_demod_pkg;

  typedef enum logic [1:0] {IDLE, HUNT, TRACK} state_e;

  localparam int MPR_DEF     = 18;
  localparam int CW_DEF      = 16;
  localparam int SYM_LEN_DEF = 256;
  localparam int CNT_THR_DEF = 6;
  localparam int HYS_DEF     = 64;
  localparam int LOS_LEN_DEF = 1024;

  // Increment x, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] x, input int w);
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (x >= mx) ? mx : x + 32'd1;
  endfunction

endpackage

// File: rtl/fsk_zc_det.sv
// Hysteretic sign tracker and carrier period counter.
module fsk_zc_det
  import fsk_demod_pkg::*;
#(
  parameter int MPR = MPR_DEF,
  parameter int CW  = CW_DEF,
  parameter int HYS = HYS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic signed [MPR-1:0] data_i,
  output logic                  rc_o,
  output logic [CW-1:0]         pc_o,
  output logic [CW-1:0]         period_o
);

  localparam logic signed [MPR-1:0] HI = MPR'(HYS);
  localparam logic signed [MPR-1:0] LO = -HI;

  logic          pos_q, pos_d;
  logic [CW-1:0] pc_q, pc_d, per_q, per_d;
  logic          above, below;

  assign above    = data_i > HI;
  assign below    = data_i < LO;
  assign rc_o     = adv_i & ~pos_q & above;
  assign pc_o     = pc_q;
  assign period_o = per_q;

  always_comb begin
    pos_d = pos_q;
    pc_d  = pc_q;
    per_d = per_q;
    if (clr_i) begin
      pos_d = 1'b0;
      pc_d  = '0;
    end else if (adv_i) begin
      if (above)      pos_d = 1'b1;
      else if (below) pos_d = 1'b0;
      // pc counts samples since the last crossing, so the crossing sample closes the period at pc+1
      if (rc_o) begin
        per_d = CW'(sat_inc(32'(pc_q), CW));
        pc_d  = '0;
      end else begin
        pc_d  = CW'(sat_inc(32'(pc_q), CW));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= 1'b0;
      pc_q  <= '0;
      per_q <= '0;
    end else begin
      pos_q <= pos_d;
      pc_q  <= pc_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/fsk_zc_demod.sv
// FSK demodulator: counts rising zero crossings per symbol window and slices them into bits.
module fsk_zc_demod
  import fsk_demod_pkg::*;
#(
  parameter int MPR     = MPR_DEF,
  parameter int CW      = CW_DEF,
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int CNT_THR = CNT_THR_DEF,
  parameter int HYS     = HYS_DEF,
  parameter int LOS_LEN = LOS_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic signed [MPR-1:0] in_data,
  output logic                  bit_o,
  output logic                  bit_valid,
  output logic [CW-1:0]         period_o,
  output logic                  locked,
  output logic                  los
);

  state_e        state_q;
  logic [CW-1:0] scnt_q, xcnt_q, scnt_inc, xcnt_nxt, pc;
  logic          bit_q, bv_q, los_q;
  logic          acc, run, clr, adv, rc, los_hit, win_end;

  assign acc = clken & in_valid;
  assign run = en & (state_q != IDLE);
  assign clr = clken & ~run;
  assign adv = acc & run;

  fsk_zc_det #(.MPR(MPR), .CW(CW), .HYS(HYS)) u_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (clr),
    .adv_i    (adv),
    .data_i   (in_data),
    .rc_o     (rc),
    .pc_o     (pc),
    .period_o (period_o)
  );

  assign los_hit  = adv & ~rc & (pc == CW'(LOS_LEN - 1));
  assign scnt_inc = scnt_q + 1'b1;
  assign xcnt_nxt = rc ? CW'(sat_inc(32'(xcnt_q), CW)) : xcnt_q;
  assign win_end  = scnt_inc == CW'(SYM_LEN);

  assign bit_o     = bit_q;
  assign bit_valid = bv_q;
  assign locked    = state_q == TRACK;
  assign los       = los_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      xcnt_q  <= '0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
      los_q   <= 1'b0;
    end else if (clken) begin
      bv_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        scnt_q  <= '0;
        xcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= HUNT;
            scnt_q  <= '0;
            xcnt_q  <= '0;
          end
          HUNT: begin
            if (los_hit) los_q <= 1'b1;
            else if (rc) begin
              // the crossing that opens the window is sample 1 but is not counted
              state_q <= TRACK;
              scnt_q  <= CW'(1);
              xcnt_q  <= '0;
              los_q   <= 1'b0;
            end
          end
          TRACK: begin
            if (los_hit) begin
              los_q   <= 1'b1;
              state_q <= HUNT;
              scnt_q  <= '0;
              xcnt_q  <= '0;
            end else if (adv) begin
              if (rc) los_q <= 1'b0;
              if (win_end) begin
                bit_q  <= xcnt_nxt >= CW'(CNT_THR);
                bv_q   <= 1'b1;
                scnt_q <= '0;
                xcnt_q <= '0;
              end else begin
                scnt_q <= scnt_inc;
                xcnt_q <= xcnt_nxt;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk_zc_demod.sv
// Directed bench for fsk_zc_demod: tones, noise, stalls, loss of signal and abort.
module tb_fsk_zc_demod;

  localparam int MPR = 18, CW = 16, SYM = 64, THR = 6, HYS = 64, LOSL = 128;
  localparam int A = 100000;

  logic                  clk = 1'b0, reset_n = 1'b0, clken = 1'b0, en = 1'b0, in_valid = 1'b0;
  logic signed [MPR-1:0] in_data = '0;
  logic                  bit_o, bit_valid, locked, los;
  logic [CW-1:0]         period_o;

  int n_chk = 0, n_fail = 0, ph = 0, pcm = 0;
  bit stall = 1'b0;

  fsk_zc_demod #(.MPR(MPR), .CW(CW), .SYM_LEN(SYM), .CNT_THR(THR), .HYS(HYS), .LOS_LEN(LOSL)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .en(en), .in_valid(in_valid), .in_data(in_data),
    .bit_o(bit_o), .bit_valid(bit_valid), .period_o(period_o), .locked(locked), .los(los)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Square tone of period p; with nz, samples carry +-50 noise and the transitions sit near zero.
  function automatic logic signed [MPR-1:0] tone(input int p, input bit nz);
    int i, v, r;
    i = ph % p;
    r = int'($urandom_range(100)) - 50;
    if (!nz)                          v = (i < p/2) ? A : -A;
    else if (i == p/2-1 || i == p-1)  v = r;
    else                              v = ((i < p/2) ? A : -A) + r;
    return MPR'(v);
  endfunction

  task automatic send(input logic signed [MPR-1:0] d);
    if (stall) begin
      repeat ($urandom_range(2)) begin
        if ($urandom_range(1) == 1) begin clken = 1'b0; in_valid = 1'b1; end
        else                        begin clken = 1'b1; in_valid = 1'b0; end
        in_data = MPR'($urandom);
        @(posedge clk); #1;
      end
    end
    clken = 1'b1; in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic win(input int p, input bit nz, input int n, input bit eb, input int ep);
    for (int k = 0; k < n; k++) begin
      send(tone(p, nz));
      ph++;
      if (k == 0)   chk("bv_clr", 32'(bit_valid), 0);
      if (k == n-2) chk("bv_pre", 32'(bit_valid), 0);
    end
    chk("bv_end", 32'(bit_valid), 1);
    chk("bit",    32'(bit_o), 32'(eb));
    chk("period", 32'(period_o), ep);
    chk("locked", 32'(locked), 1);
  endtask

  initial begin
    #12;
    chk("rst_bit",    32'(bit_o), 0);
    chk("rst_bv",     32'(bit_valid), 0);
    chk("rst_period", 32'(period_o), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_los",    32'(los), 0);

    reset_n = 1'b1; clken = 1'b1; en = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hunt_unlocked", 32'(locked), 0);

    ph = 0;
    send(tone(8, 1'b0)); ph++;
    chk("first_lock",   32'(locked), 1);
    chk("first_period", 32'(period_o), 1);
    win(8, 1'b0, 63, 1'b1, 8);          // opening crossing not counted: 7 crossings
    win(8, 1'b0, 64, 1'b1, 8);
    win(16, 1'b0, 64, 1'b0, 16);
    win(8, 1'b0, 64, 1'b1, 8);
    win(16, 1'b0, 64, 1'b0, 16);
    win(16, 1'b0, 64, 1'b0, 16);
    win(8, 1'b1, 64, 1'b1, 8);
    win(8, 1'b1, 64, 1'b1, 8);

    stall = 1'b1;
    win(8, 1'b0, 64, 1'b1, 8);
    win(16, 1'b0, 64, 1'b0, 16);
    win(8, 1'b0, 64, 1'b1, 8);
    stall = 1'b0;

    // Silence: last crossing was 7 samples before the window boundary.
    pcm = 7;
    for (int k = 1; k <= 130; k++) begin
      send('0);
      if (pcm == LOSL-2) begin
        chk("pre_los",    32'(los), 0);
        chk("pre_locked", 32'(locked), 1);
      end
      if (pcm == LOSL-1) begin
        chk("los_set",    32'(los), 1);
        chk("los_unlock", 32'(locked), 0);
        chk("los_no_bv",  32'(bit_valid), 0);
      end
      if (k == SYM) begin
        chk("zero_win_bv",  32'(bit_valid), 1);
        chk("zero_win_bit", 32'(bit_o), 0);
      end
      pcm++;
    end
    chk("los_sticky", 32'(los), 1);

    ph = 0;
    send(tone(8, 1'b0)); ph++;
    chk("los_clear",     32'(los), 0);
    chk("relock",        32'(locked), 1);
    chk("relock_period", 32'(period_o), pcm + 1);
    win(8, 1'b0, 63, 1'b1, 8);

    for (int k = 0; k < 63; k++) begin send(tone(8, 1'b0)); ph++; end
    en = 1'b0;
    send(tone(8, 1'b0)); ph++;
    chk("abort_bv",     32'(bit_valid), 0);
    chk("abort_locked", 32'(locked), 0);
    chk("abort_bit",    32'(bit_o), 1);
    chk("abort_period", 32'(period_o), 8);
    en = 1'b1;
    @(posedge clk); #1;
    chk("reen_hunt", 32'(locked), 0);
    ph = 0;
    send(tone(8, 1'b0)); ph++;
    chk("reen_lock",   32'(locked), 1);
    chk("reen_period", 32'(period_o), 1);
    for (int k = 0; k < 30; k++) begin send(tone(8, 1'b0)); ph++; end

    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("arst_bit",    32'(bit_o), 0);
    chk("arst_bv",     32'(bit_valid), 0);
    chk("arst_period", 32'(period_o), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_los",    32'(los), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
